// File: rtl/hdmi_video_timing_ctrl.sv
// hdmi_video_timing_ctrl
//   Video timing generator for a TMDS encoder. Walks a raster of
//   H_TOTAL x V_TOTAL pixel clocks, pulls pixels from a valid-qualified
//   source during the active region, and emits registered sync/DE/RGB with
//   a single cycle of latency. Starved pixels are replaced by black and
//   counted; the raster itself never stalls.
// Ports
//   i_pixclk, i_reset        : pixel clock, synchronous active-high reset
//   i_enable                 : run request; a stop completes the current frame
//   i_pix_data/i_pix_valid   : pixel source {B,G,R}
//   o_pix_ready              : pixel consumed this cycle (active region)
//   o_rgb_data               : registered pixel, black in blanking/underflow
//   o_hsync/o_vsync/o_de     : registered timing
//   o_x/o_y                  : active coordinate of o_rgb_data (0 in blanking)
//   o_frame_start/o_line_start : first DE of frame / line
//   o_underflow/o_underflow_cnt : starvation pulse and saturating count
module hdmi_video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [23:0] i_pix_data,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic [23:0] o_rgb_data,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start,
  output logic        o_line_start,
  output logic        o_underflow,
  output logic [15:0] o_underflow_cnt
);

  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS_C   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_C = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS_C   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE_C   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_C = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [11:0] hc_q, hc_d, vc_q, vc_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        fs_q, fs_d, ls_q, ls_d, uf_q, uf_d;
  logic [15:0] ufc_q, ufc_d;

  logic running, act, h_last, v_last;

  always_comb begin
    running = (state_q != S_IDLE);
    h_last  = (hc_q == H_LAST_C);
    v_last  = (vc_q == V_LAST_C);
    act     = running && (hc_q < H_ACT_C) && (vc_q < V_ACT_C);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_enable) state_d = S_RUN;
      S_RUN:   if (!i_enable) state_d = S_STOP;
      S_STOP: begin
        // A re-enable before the last pixel of the frame cancels the stop.
        if (i_enable)             state_d = S_RUN;
        else if (h_last && v_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Counters hold at 0 in IDLE; the frame-end wrap returns them to 0,
    // so entering IDLE needs no separate clear.
    hc_d = hc_q;
    vc_d = vc_q;
    if (running) begin
      if (h_last) begin
        hc_d = 12'd0;
        vc_d = v_last ? 12'd0 : vc_q + 12'd1;
      end else begin
        hc_d = hc_q + 12'd1;
      end
    end

    de_d  = act;
    rgb_d = (act && i_pix_valid) ? i_pix_data : 24'h000000;
    x_d   = act ? hc_q : 12'd0;
    y_d   = act ? vc_q : 12'd0;
    fs_d  = act && (hc_q == 12'd0) && (vc_q == 12'd0);
    ls_d  = act && (hc_q == 12'd0);
    uf_d  = act && !i_pix_valid;
    hs_d  = (running && hc_q >= H_SS_C && hc_q < H_SE_C) ? HS_POL : ~HS_POL;
    vs_d  = (running && vc_q >= V_SS_C && vc_q < V_SE_C) ? VS_POL : ~VS_POL;

    ufc_d = ufc_q;
    if (uf_d && ufc_q != 16'hFFFF) ufc_d = ufc_q + 16'd1;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      hc_q    <= 12'd0;
      vc_q    <= 12'd0;
      rgb_q   <= 24'h000000;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      uf_q    <= 1'b0;
      ufc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      uf_q    <= uf_d;
      ufc_q   <= ufc_d;
    end
  end

  assign o_pix_ready     = act;
  assign o_rgb_data      = rgb_q;
  assign o_hsync         = hs_q;
  assign o_vsync         = vs_q;
  assign o_de            = de_q;
  assign o_x             = x_q;
  assign o_y             = y_q;
  assign o_frame_start   = fs_q;
  assign o_line_start    = ls_q;
  assign o_underflow     = uf_q;
  assign o_underflow_cnt = ufc_q;

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Bench for hdmi_video_timing_ctrl on a shrunken raster so several frames
// fit in a short run. Two instances share stimulus: one with active-low
// syncs, one with active-high. Expected values come from a position-based
// raster model (pixel index within the frame).
module tb_hdmi_video_timing_ctrl;
  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 12, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;

  logic        gclk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, valid = 1'b0;
  logic [23:0] data = 24'd0;
  always #5 gclk = ~gclk;

  logic        rdy0, hs0, vs0, de0, fs0, ls0, uf0;
  logic [23:0] rgb0;
  logic [11:0] x0, y0;
  logic [15:0] ufc0;
  logic        rdy1, hs1, vs1, de1, fs1, ls1, uf1;
  logic [23:0] rgb1;
  logic [11:0] x1, y1;
  logic [15:0] ufc1;

  hdmi_video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .HS_POL(1'b0), .VS_POL(1'b0)) dut0 (
    .i_pixclk(gclk), .i_reset(rst), .i_enable(en), .i_pix_data(data), .i_pix_valid(valid),
    .o_pix_ready(rdy0), .o_rgb_data(rgb0), .o_hsync(hs0), .o_vsync(vs0), .o_de(de0),
    .o_x(x0), .o_y(y0), .o_frame_start(fs0), .o_line_start(ls0),
    .o_underflow(uf0), .o_underflow_cnt(ufc0));

  hdmi_video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .HS_POL(1'b1), .VS_POL(1'b1)) dut1 (
    .i_pixclk(gclk), .i_reset(rst), .i_enable(en), .i_pix_data(data), .i_pix_valid(valid),
    .o_pix_ready(rdy1), .o_rgb_data(rgb1), .o_hsync(hs1), .o_vsync(vs1), .o_de(de1),
    .o_x(x1), .o_y(y1), .o_frame_start(fs1), .o_line_start(ls1),
    .o_underflow(uf1), .o_underflow_cnt(ufc1));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: m_on = raster running, m_p = pixel index in frame,
  // m_low = enable was low at the last running edge (a stop is pending).
  bit m_on = 0, m_low = 0, inc_data = 1;
  int m_p = 0, m_cnt = 0;

  task automatic cyc();
    int hc, vc;
    bit act, xfer, e_hs, e_vs;
    logic [23:0] e_rgb;
    hc = m_p % HT;
    vc = m_p / HT;
    act = !rst && m_on && hc < HA && vc < VA;
    xfer = act && valid;
    e_rgb = xfer ? data : 24'd0;
    e_hs = !rst && m_on && hc >= HA + HFP && hc < HA + HFP + HSW;
    e_vs = !rst && m_on && vc >= VA + VFP && vc < VA + VFP + VSW;
    if (rst) begin
      m_on = 0; m_p = 0; m_low = 0; m_cnt = 0;
    end else if (!m_on) begin
      m_on = en; m_low = 0;
    end else begin
      // Stop completes at the frame's last pixel only if enable stayed low.
      if (m_p == FR - 1 && !en && m_low) m_on = 0;
      m_p = (m_p + 1) % FR;
      m_low = !en;
      if (act && !valid && m_cnt < 65535) m_cnt++;
    end
    @(posedge gclk);
    #1;
    chk("de", de0, act);
    chk("rgb", rgb0, e_rgb);
    chk("x", x0, act ? hc : 0);
    chk("y", y0, act ? vc : 0);
    chk("frame_start", fs0, act && hc == 0 && vc == 0);
    chk("line_start", ls0, act && hc == 0);
    chk("underflow", uf0, act && !valid);
    chk("underflow_cnt", ufc0, m_cnt);
    chk("hsync_lo", hs0, !e_hs);
    chk("vsync_lo", vs0, !e_vs);
    chk("hsync_hi", hs1, e_hs);
    chk("vsync_hi", vs1, e_vs);
    chk("de_hi", de1, act);
    chk("pix_ready", rdy0, m_on && (m_p % HT) < HA && (m_p / HT) < VA);
    if (inc_data && xfer) data = data + 24'd1;
  endtask

  // Advance until the model reaches pixel index p while running.
  task automatic run_to(input int p);
    for (int i = 0; i < 2 * FR; i++) begin
      if (m_on && m_p == p) return;
      cyc();
    end
    n_cmp++; n_bad++;
    $display("FAIL run_to: timeout got no position want %0d", p);
  endtask

  int last_fs, de_cnt, k;

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    repeat (3) cyc();                       // IDLE holds reset-level outputs

    // Start with a continuously valid, incrementing source.
    en = 1'b1; valid = 1'b1; data = 24'h000100;
    cyc();
    chk("ready_first", rdy0, 1'b1);
    cyc();
    chk("first_fs", fs0, 1'b1);
    chk("first_rgb", rgb0, 24'h000100);

    // Two free-running frames: frame length and DE count from the outputs.
    last_fs = 0; de_cnt = 1;
    for (k = 1; k < 2 * FR + 4; k++) begin
      cyc();
      if (fs0) begin
        chk("frame_len", k - last_fs, FR);
        chk("de_per_frame", de_cnt, HA * VA);
        last_fs = k; de_cnt = 0;
      end
      if (de0) de_cnt++;
    end
    chk("no_underflow", ufc0, 16'd0);

    // Five starved active pixels on line 3.
    run_to(3 * HT + 2);
    valid = 1'b0;
    repeat (5) cyc();
    valid = 1'b1;
    repeat (3) cyc();
    chk("uf_burst_cnt", ufc0, 16'd5);

    // Stop request, cancelled, then a real stop that completes the frame.
    run_to(5 * HT);
    en = 1'b0;
    run_to(8 * HT);
    en = 1'b1;
    run_to(10 * HT);
    en = 1'b0;
    run_to(FR - 1);
    cyc();
    chk("stopped_ready", rdy0, 1'b0);
    repeat (HT) cyc();
    chk("idle_de", de0, 1'b0);
    chk("idle_hs", hs0, 1'b1);

    // Reset mid-frame with enable held: fresh frame follows.
    en = 1'b1;
    cyc();
    run_to(7 * HT + 9);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_de", de0, 1'b0);
    chk("rst_cnt", ufc0, 16'd0);
    cyc();
    cyc();
    chk("rst_restart_fs", fs0, 1'b1);

    // Random traffic, enable toggles and occasional resets.
    inc_data = 0;
    for (int i = 0; i < 4000; i++) begin
      data = 24'($urandom);
      valid = ($urandom % 4) != 0;
      if ($urandom % 300 == 0) en = ~en;
      rst = ($urandom % 1500 == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hdmi_video_timing_ctrl.md
HDMI_VIDEO_TIMING_CTRL -- requirements
Module: hdmi_video_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels.
REQ-003 Parameter V_ACTIVE, 480, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines.
REQ-005 Parameter HS_POL / VS_POL, 0 / 0, sync asserted level (0 = active-low).
REQ-006 i_pixclk  in  1  pixel clock; the only clock.
REQ-007 i_reset  in  1  synchronous, active-high reset.
REQ-008 i_enable  in  1  run request; stop takes effect at frame boundary.
REQ-009 i_pix_data  in  24  pixel {B[23:16],G[15:8],R[7:0]}.
REQ-010 i_pix_valid  in  1  i_pix_data valid.
REQ-011 o_pix_ready  out  1  pixel consumed this cycle.
REQ-012 o_rgb_data  out  24  registered pixel to the TMDS encoder.
REQ-013 o_hsync / o_vsync / o_de  out  1 each  registered timing to the encoder.
REQ-014 o_x / o_y  out  12 each  active-region coordinate of the o_rgb_data pixel.
REQ-015 o_frame_start / o_line_start  out  1 each  one-cycle pulses, aligned with the first o_de of a frame / line.
REQ-016 o_underflow  out  1  one-cycle pulse, pixel demanded but not valid.
REQ-017 o_underflow_cnt  out  16  saturating underflow count.

Function
REQ-018 Internal counters: hc counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; vc counts 0..V_TOTAL-1, defined likewise.
REQ-019 Line order: active [0,H_ACTIVE), FP, sync, BP; frame order is the same for vc.
REQ-020 hc wraps to 0 after H_TOTAL-1, and vc increments on that wrap; vc wraps to 0 after V_TOTAL-1 at the hc wrap.
REQ-021 FSM states IDLE, RUN, STOPPING; reset state IDLE.
REQ-022 IDLE: hc = vc = 0 and held; all outputs at their reset values.
REQ-023 IDLE -> RUN when i_enable = 1; counting starts the following cycle at hc = vc = 0.
REQ-024 RUN -> STOPPING when i_enable = 0.
REQ-025 STOPPING: counting continues; -> IDLE on the hc = H_TOTAL-1 && vc = V_TOTAL-1 cycle.
REQ-026 STOPPING -> RUN if i_enable returns to 1 before the frame end; no timing disturbance.
REQ-027 Active: act = (hc < H_ACTIVE) && (vc < V_ACTIVE) && state != IDLE.
REQ-028 o_pix_ready = act, combinational from registered state.
REQ-029 Pixel transfer occurs on o_pix_ready && i_pix_valid.
REQ-030 The source may hold i_pix_valid high continuously; i_pix_valid outside active is ignored and not consumed.
REQ-031 Output timing: o_hsync, o_vsync, o_de, o_rgb_data, o_x, o_y, o_frame_start and o_line_start are registered, one cycle after the hc/vc that produced them; all share one latency.
REQ-032 o_hsync = HS_POL during the hc sync region, else ~HS_POL.
REQ-033 o_vsync = VS_POL during the vc sync region (all hc of those lines), else ~VS_POL.
REQ-034 o_rgb_data = i_pix_data on transfer.
REQ-035 o_rgb_data = 24'h000000 in blanking and on underflow.
REQ-036 Underflow: act && !i_pix_valid gives o_rgb_data = black and o_de = 1 (timing never stalls).
REQ-037 Underflow also pulses o_underflow (registered, same latency) and increments o_underflow_cnt, saturating at 16'hFFFF.
REQ-038 o_x = hc and o_y = vc when active; o_x = o_y = 0 otherwise.
REQ-039 o_frame_start = 1 for hc = 0 && vc = 0 && active; o_line_start = 1 for hc = 0 && active.

Reset
REQ-040 On i_reset = 1 at a clock edge: state IDLE, hc = vc = 0, o_de = 0, o_rgb_data = 0, o_x = o_y = 0, pulses 0, o_underflow_cnt = 0.
REQ-041 On reset: o_hsync = ~HS_POL, o_vsync = ~VS_POL, o_pix_ready = 0.
REQ-042 Reset mid-frame or mid-STOPPING aborts immediately, with no frame completion.
REQ-043 Reset has priority over i_enable in the same cycle.

Verification
REQ-044 Reset, then i_enable = 1 with i_pix_valid = 1 and incrementing data: first o_de one cycle after the first o_pix_ready, o_frame_start = 1 there, o_x = o_y = 0, o_rgb_data = the first word.
REQ-045 Free run of 2 frames at defaults: 800 clocks per line, 525 lines per frame, 640 de per line, 480 de lines, o_hsync low 96 clocks starting at hc = 656, o_vsync low for lines 490-491, o_underflow_cnt = 0.
REQ-046 i_pix_valid = 0 for 5 active cycles at line 10: 5 black pixels with o_de = 1, 5 o_underflow pulses, o_underflow_cnt = 5, line length unchanged.
REQ-047 i_enable = 0 at line 100: frame completes to vc = 524 and hc = 799, then IDLE.
REQ-048 i_enable = 0 at line 100 (continued): no further o_de, syncs at inactive level.
REQ-049 i_reset pulse at hc = 300, vc = 200: next cycle o_de = 0 and counters 0; i_enable still 1 gives a fresh frame with o_frame_start.
REQ-050 HS_POL = VS_POL = 1 build: sync pulses high, idle level low, widths unchanged.
